// File: rtl/decode_pkg.sv
// RV32I decode definitions: opcodes, instruction classes, decoded payload.
// Pure combinational helpers; no state, no latency.
// Backpressure: not applicable.
package decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_LUI    = 4'd1,
        CLS_AUIPC  = 4'd2,
        CLS_JAL    = 4'd3,
        CLS_JALR   = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_LOAD   = 4'd6,
        CLS_STORE  = 4'd7,
        CLS_OPIMM  = 4'd8,
        CLS_OP     = 4'd9,
        CLS_FENCE  = 4'd10,
        CLS_SYSTEM = 4'd11
    } insn_class_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  shamt;
        logic [31:0] imm;
        insn_class_e itype;
        logic        illegal;
    } dec_payload_t;

    function automatic insn_class_e classify(input logic [6:0] opc);
        insn_class_e c;
        case (opc)
            OP_LUI:    c = CLS_LUI;
            OP_AUIPC:  c = CLS_AUIPC;
            OP_JAL:    c = CLS_JAL;
            OP_JALR:   c = CLS_JALR;
            OP_BRANCH: c = CLS_BRANCH;
            OP_LOAD:   c = CLS_LOAD;
            OP_STORE:  c = CLS_STORE;
            OP_OPIMM:  c = CLS_OPIMM;
            OP_OP:     c = CLS_OP;
            OP_FENCE:  c = CLS_FENCE;
            OP_SYSTEM: c = CLS_SYSTEM;
            default:   c = CLS_NONE;
        endcase
        return c;
    endfunction

    function automatic logic is_illegal(input logic [31:0] insn);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ill;
        f3  = insn[14:12];
        f7  = insn[31:25];
        ill = 1'b0;
        // Every valid opcode ends in 2'b11, so a bad low pair also falls into default.
        case (insn[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE: ill = 1'b0;
            OP_JALR:   ill = (f3 != 3'b000);
            OP_BRANCH: ill = (f3 == 3'b010) || (f3 == 3'b011);
            OP_LOAD:   ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            OP_STORE:  ill = (f3 > 3'b010);
            OP_OP:     ill = !((f7 == 7'b0000000) ||
                               ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            OP_OPIMM: begin
                if (f3 == 3'b001)
                    ill = (f7 != 7'b0000000);
                else if (f3 == 3'b101)
                    ill = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
                else
                    ill = 1'b0;
            end
            OP_SYSTEM: ill = (insn != 32'h0000_0073) && (insn != 32'h0010_0073);
            default:   ill = 1'b1;
        endcase
        return ill;
    endfunction

    function automatic dec_payload_t decode_payload(input logic [31:0] insn,
                                                    input logic [31:0] pc,
                                                    input logic [31:0] imm);
        dec_payload_t p;
        p         = '0;
        p.pc      = pc;
        p.insn    = insn;
        p.opcode  = insn[6:0];
        p.rd      = insn[11:7];
        p.rs1     = insn[19:15];
        p.rs2     = insn[24:20];
        p.funct3  = insn[14:12];
        p.funct7  = insn[31:25];
        p.shamt   = insn[24:20];
        p.imm     = imm;
        p.itype   = classify(insn[6:0]);
        p.illegal = is_illegal(insn);
        return p;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_igen.sv
// RV32I immediate generator: sign-extended I/S/B/U/J immediates, 0 otherwise.
// Latency: combinational.
// Backpressure: not applicable.
module igen
    import decode_pkg::*;
(
    input  logic [31:0] insn,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (insn[6:0])
            OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM, OP_FENCE:
                imm = {{20{insn[31]}}, insn[31:20]};
            OP_STORE:
                imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            OP_BRANCH:
                imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {insn[31:12], 12'b0};
            OP_JAL:
                imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered RV32I decode stage between fetch and execute.
// Latency: 1 cycle from accept to valid_o.
// Backpressure: valid/ready; optional 2-entry skid makes ready_o a flop, flush drops everything.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [4:0]        shamt_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic [3:0]        itype_o,
    output logic              illegal_o
);

    if (DWIDTH != 32) begin : g_bad_dwidth
        $error("decode_stage_pipe: DWIDTH must be 32");
    end
    if (AWIDTH < 1 || AWIDTH > 32) begin : g_bad_awidth
        $error("decode_stage_pipe: AWIDTH must be 1..32");
    end

    logic [31:0]  imm_dec;
    logic [31:0]  pc_ext;
    dec_payload_t in_pl;

    igen u_igen (
        .insn (insn_i[31:0]),
        .imm  (imm_dec)
    );

    assign pc_ext = 32'(pc_i);
    assign in_pl  = decode_payload(insn_i[31:0], pc_ext, imm_dec);

    logic         out_vld;
    dec_payload_t out_pl;
    logic         skid_vld;
    dec_payload_t skid_pl;
    logic         rdy_q;

    logic accept;
    logic xfer;
    logic out_vld_nx;
    logic skid_vld_nx;
    logic load_out;
    logic load_out_skid;
    logic load_skid;

    assign ready_o = SKID_EN ? rdy_q : (~out_vld | ready_i);
    assign accept  = valid_i & ready_o;
    assign xfer    = out_vld & ready_i;

    // With the skid full ready_o is low, so accept and skid drain never coincide.
    always_comb begin
        out_vld_nx    = out_vld;
        skid_vld_nx   = skid_vld;
        load_out      = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (skid_vld) begin
            if (xfer) begin
                load_out_skid = 1'b1;
                out_vld_nx    = 1'b1;
                skid_vld_nx   = 1'b0;
            end
        end else if (accept) begin
            if (SKID_EN && out_vld && !ready_i) begin
                load_skid   = 1'b1;
                skid_vld_nx = 1'b1;
            end else begin
                load_out   = 1'b1;
                out_vld_nx = 1'b1;
            end
        end else if (xfer) begin
            out_vld_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_pl   <= '0;
            skid_pl  <= '0;
            rdy_q    <= 1'b1;
        end else if (flush_i) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            out_vld  <= out_vld_nx;
            skid_vld <= skid_vld_nx;
            rdy_q    <= ~skid_vld_nx;
            if (load_out)
                out_pl <= in_pl;
            else if (load_out_skid)
                out_pl <= skid_pl;
            if (load_skid)
                skid_pl <= in_pl;
        end
    end

    assign valid_o   = out_vld;
    assign pc_o      = out_pl.pc[AWIDTH-1:0];
    assign insn_o    = out_pl.insn;
    assign opcode_o  = out_pl.opcode;
    assign rd_o      = out_pl.rd;
    assign rs1_o     = out_pl.rs1;
    assign rs2_o     = out_pl.rs2;
    assign funct3_o  = out_pl.funct3;
    assign funct7_o  = out_pl.funct7;
    assign shamt_o   = out_pl.shamt;
    assign imm_o     = out_pl.imm;
    assign itype_o   = out_pl.itype;
    assign illegal_o = out_pl.illegal;

endmodule
